// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: FSM/op types and SPI core register map shared by spi_xfer_sequencer
package spi_seq_pkg;
  typedef enum logic [2:0] {IDLE, W_SPCR, W_SPER, W_SS, XFER, W_SSCLR, ABORT, DONE} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_POP, OP_PUSH, OP_POLL} op_e;
  localparam logic [2:0] ADR_SPCR = 3'd0, ADR_SPSR = 3'd1, ADR_SPDR = 3'd2, ADR_SPER = 3'd3, ADR_SS = 3'd4;
  localparam int RFEMPTY = 0, RFFULL = 1, WFEMPTY = 2, WFFULL = 3, WCOL = 6, SPIF = 7, SPE_BIT = 6;
  localparam logic [7:0] SPE_MASK = 8'h01 << SPE_BIT;
endpackage

// File: rtl/spi_seq_wb_master.sv
// spi_seq_wb_master: single-outstanding Wishbone access; bus held until ack, dropped the cycle after
module spi_seq_wb_master (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [2:0] adr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);
  logic       busy_q, we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  always_ff @(posedge clk_i)
    if (rst_i || (busy_q && wb_ack_i)) begin
      busy_q <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
    end else if (!busy_q && start_i) begin
      busy_q <= 1'b1;
      we_q   <= we_i;
      adr_q  <= adr_i;
      dat_q  <= wdata_i;
    end
  assign busy_o   = busy_q;
  assign done_o   = busy_q & wb_ack_i;
  assign rdata_o  = wb_dat_i;
  assign wb_cyc_o = busy_q;
  assign wb_stb_o = busy_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: drives the SPI core register bus to run multi-byte transfers with SS ownership.
// Optional poll watchdog with flush/abort enabled by `define SPI_SEQ_TIMEOUT_EN.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int SS_WIDTH     = 2,
  parameter int LEN_W        = 16,
  parameter int MAX_INFLIGHT = 4,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          cfg_spcr_i,
  input  logic [7:0]          cfg_sper_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [SS_WIDTH-1:0] cmd_ss_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic                cmd_keep_i,
  input  logic                tx_valid_i,
  input  logic [7:0]          tx_data_i,
  output logic                tx_ready_o,
  output logic                rx_valid_o,
  output logic [7:0]          rx_data_o,
  input  logic                rx_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                spi_cyc_o,
  output logic                spi_stb_o,
  output logic                spi_we_o,
  output logic [2:0]          spi_adr_o,
  output logic [7:0]          spi_dat_o,
  input  logic [7:0]          spi_dat_i,
  input  logic                spi_ack_i
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [SS_WIDTH-1:0] ss_q;
  logic [LEN_W-1:0]    len_q, pushed_q, pushed_d, popped_q, popped_d;
  logic [IW-1:0]       infl_q, infl_d, known_q, known_d;
  logic                keep_q, rx_valid_q, rx_valid_d;
  logic [7:0]          rx_data_q, rx_data_d, wb_wdata, wb_rdata;
  logic [2:0]          wb_adr;
  logic                wb_start, wb_we, wb_busy, wb_done, accept, to_hit;
  logic                do_pop, do_push, do_poll, xfer_end;
  assign accept   = cmd_valid_i && state_q == IDLE;
  assign do_pop   = known_q != '0 && !rx_valid_q;
  assign do_push  = tx_valid_i && pushed_q < len_q && infl_q < IW'(MAX_INFLIGHT);
  assign do_poll  = infl_q > known_q;
  assign xfer_end = popped_q == len_q && !rx_valid_q;
  always_ff @(posedge clk_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = cmd_valid_i ? W_SPCR : IDLE;
      W_SPCR:  state_d = wb_done ? W_SPER : W_SPCR;
      W_SPER:  state_d = wb_done ? W_SS : W_SPER;
      W_SS:    state_d = !wb_done ? W_SS : len_q != '0 ? XFER : keep_q ? DONE : W_SSCLR;
      XFER:    state_d = wb_busy ? XFER : to_hit ? ABORT : !xfer_end ? XFER : keep_q ? DONE : W_SSCLR;
      W_SSCLR: state_d = wb_done ? DONE : W_SSCLR;
      ABORT:   state_d = wb_done ? W_SSCLR : ABORT;
      default: state_d = IDLE;
    endcase
  end
  // In XFER one access per free slot: drain RX first, then feed TX, then poll status
  always_comb begin
    op_d = OP_NONE;
    if (state_q == XFER && !wb_busy && !to_hit)
      op_d = do_pop ? OP_POP : do_push ? OP_PUSH : do_poll ? OP_POLL : OP_NONE;
    wb_start = !wb_busy && (state_q inside {W_SPCR, W_SPER, W_SS, W_SSCLR, ABORT} || op_d != OP_NONE);
    wb_we    = state_q != XFER || op_d == OP_PUSH;
    wb_adr   = state_q inside {W_SPCR, ABORT} ? ADR_SPCR :
               state_q == W_SPER ? ADR_SPER :
               state_q == XFER ? (op_d == OP_POLL ? ADR_SPSR : ADR_SPDR) : ADR_SS;
    wb_wdata = state_q == W_SPCR ? (cfg_spcr_i | SPE_MASK) :
               state_q == ABORT  ? (cfg_spcr_i & ~SPE_MASK) :
               state_q == W_SPER ? cfg_sper_i :
               state_q == W_SS   ? 8'(ss_q) :
               state_q == XFER   ? tx_data_i : 8'h00;
  end
  always_comb begin
    pushed_d   = pushed_q;
    popped_d   = popped_q;
    infl_d     = infl_q;
    known_d    = known_q;
    rx_valid_d = rx_valid_q & ~rx_ready_i;
    rx_data_d  = rx_data_q;
    if (accept) begin
      pushed_d = '0;
      popped_d = '0;
      infl_d   = '0;
      known_d  = '0;
    end else if (wb_done && op_q == OP_POP) begin
      popped_d   = popped_q + 1'b1;
      infl_d     = infl_q - 1'b1;
      known_d    = known_q - 1'b1;
      rx_valid_d = 1'b1;
      rx_data_d  = wb_rdata;
    end else if (wb_done && op_q == OP_PUSH) begin
      pushed_d = pushed_q + 1'b1;
      infl_d   = infl_q + 1'b1;
    end else if (wb_done && op_q == OP_POLL && !wb_rdata[RFEMPTY])
      known_d = known_q + 1'b1;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      op_q       <= OP_NONE;
      ss_q       <= '0;
      len_q      <= '0;
      keep_q     <= 1'b0;
      pushed_q   <= '0;
      popped_q   <= '0;
      infl_q     <= '0;
      known_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      if (!wb_busy) op_q <= op_d;
      if (accept) begin
        ss_q   <= cmd_ss_i;
        len_q  <= cmd_len_i;
        keep_q <= cmd_keep_i;
      end
      pushed_q   <= pushed_d;
      popped_q   <= popped_d;
      infl_q     <= infl_d;
      known_q    <= known_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
  logic          err_q;
  assign to_hit = to_q >= TW'(TIMEOUT_CYC);
  assign to_d   = (state_q != XFER || (wb_done && op_q == OP_POP)) ? '0 :
                  (infl_q != '0 && !to_hit) ? to_q + 1'b1 : to_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= accept ? 1'b0 : (state_q == XFER && state_d == ABORT) ? 1'b1 : err_q;
    end
  assign err_o = done_o & err_q;
`else
  assign to_hit = 1'b0;
  assign err_o  = 1'b0;
`endif
  spi_seq_wb_master u_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (wb_start),
    .we_i     (wb_we),
    .adr_i    (wb_adr),
    .wdata_i  (wb_wdata),
    .busy_o   (wb_busy),
    .done_o   (wb_done),
    .rdata_o  (wb_rdata),
    .wb_cyc_o (spi_cyc_o),
    .wb_stb_o (spi_stb_o),
    .wb_we_o  (spi_we_o),
    .wb_adr_o (spi_adr_o),
    .wb_dat_o (spi_dat_o),
    .wb_dat_i (spi_dat_i),
    .wb_ack_i (spi_ack_i)
  );
  assign cmd_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign done_o      = state_q == DONE;
  assign tx_ready_o  = wb_done && op_q == OP_PUSH;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: SPI core register model with MOSI->MISO loopback and an RX scoreboard
module tb_spi_xfer_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0]  cfg_spcr = 8'h13, cfg_sper = 8'h02;
  logic        cmd_valid = 1'b0, cmd_keep = 1'b0, cmd_ready_o;
  logic [1:0]  cmd_ss = '0;
  logic [15:0] cmd_len = '0;
  logic        tx_valid_i = 1'b0, tx_ready_o, rx_valid_o, rx_ready_i = 1'b1;
  logic [7:0]  tx_data_i = '0, rx_data_o;
  logic        busy_o, done_o, err_o, spi_cyc_o, spi_stb_o, spi_we_o;
  logic [2:0]  spi_adr_o;
  logic [7:0]  spi_dat_o, dat_i = '0;
  logic        ack = 1'b0;
  logic [7:0]  fifo[$], txq[$], exp_q[$];
  logic [11:0] log_q[$], filt[$];
  logic [11:0] t2_exp[6] = '{12'h853, 12'hB02, 12'hC01, 12'hAA5, 12'h2A5, 12'hC00};
  logic [7:0]  spcr_m = '0, ss_m = '0;
  logic        stuck = 1'b0, last_err = 1'b0;
  int          max_fill = 0, bad = 0, n_done = 0, errors = 0, checks = 0, n0 = 0, c = 0;

  spi_xfer_sequencer #(.SS_WIDTH(2), .LEN_W(16), .MAX_INFLIGHT(4), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_spcr_i(cfg_spcr), .cfg_sper_i(cfg_sper),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_ss_i(cmd_ss), .cmd_len_i(cmd_len),
    .cmd_keep_i(cmd_keep), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .spi_cyc_o(spi_cyc_o), .spi_stb_o(spi_stb_o), .spi_we_o(spi_we_o),
    .spi_adr_o(spi_adr_o), .spi_dat_o(spi_dat_o), .spi_dat_i(dat_i), .spi_ack_i(ack));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Registered ack like the real core; writes to SPDR loop straight back into the read FIFO
  always @(posedge clk) begin
    logic [7:0] r;
    ack <= 1'b0;
    if (spi_cyc_o && spi_stb_o && !ack) begin
      ack <= 1'b1;
      if (spi_we_o) begin
        if (spi_adr_o == 3'd2 && !stuck) begin
          if (fifo.size() >= 4) bad++;
          fifo.push_back(spi_dat_o);
          if (fifo.size() > max_fill) max_fill = fifo.size();
        end
        if (spi_adr_o == 3'd0) spcr_m = spi_dat_o;
        if (spi_adr_o == 3'd4) ss_m = spi_dat_o;
        log_q.push_back({1'b1, spi_adr_o, spi_dat_o});
      end else begin
        r = 8'h00;
        if (spi_adr_o == 3'd1) r = stuck ? 8'h05 : {5'b0, 1'b1, 1'b0, fifo.size() == 0};
        else if (spi_adr_o == 3'd2) begin
          if (fifo.size() == 0) bad++;
          else r = fifo.pop_front();
        end
        dat_i <= r;
        log_q.push_back({1'b0, spi_adr_o, r});
      end
    end
  end

  always @(posedge clk) begin
    if (tx_valid_i && tx_ready_o) void'(txq.pop_front());
    #1;
    tx_valid_i = txq.size() != 0;
    if (txq.size() != 0) tx_data_i = txq[0];
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (done_o) begin
      n_done++;
      last_err = err_o;
    end
    if (rx_valid_o && rx_ready_i) begin
      e = exp_q.size() != 0 ? {1'b0, exp_q.pop_front()} : 9'h100;
      chk("rx_data", {24'h0, rx_data_o}, {23'h0, e});
    end
  end

  task automatic load(input logic [7:0] b);
    txq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic send_cmd(input logic [1:0] ss, input logic [15:0] len, input logic keep);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ss = ss; cmd_len = len; cmd_keep = keep;
    for (int i = 0; i < 1000 && !cmd_ready_o; i++) @(negedge clk);
    chk("cmd_accept", cmd_ready_o, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int base = n_done;
    for (int i = 0; i < lim && n_done == base; i++) @(posedge clk);
    chk({tag, "_done_seen"}, n_done > base, 1);
  endtask

  function automatic int count_ent(input logic [11:0] v, input logic [11:0] mask);
    int n = 0;
    foreach (log_q[i]) if ((log_q[i] & mask) == v) n++;
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {cmd_ready_o, busy_o, done_o, err_o, rx_valid_o, tx_ready_o, spi_cyc_o, spi_stb_o, spi_we_o}, 9'b100000000);
    chk("rst_bus", {spi_adr_o, spi_dat_o, rx_data_o}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_no_wb", log_q.size(), 0);
    chk("idle_ready", {cmd_ready_o, busy_o, spi_cyc_o}, 3'b100);

    log_q.delete();
    n0 = n_done;
    load(8'hA5);
    send_cmd(2'b01, 16'd1, 1'b0);
    wait_done(400, "t2");
    repeat (3) @(posedge clk);
    filt.delete();
    foreach (log_q[i]) if (log_q[i][10:8] != 3'd1) filt.push_back(log_q[i]);
    chk("t2_len", filt.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_acc%0d", i), i < filt.size() ? filt[i] : 12'hFFF, t2_exp[i]);
    chk("t2_polled", count_ent(12'h100, 12'hF00) > 0, 1);
    chk("t2_one_done", n_done - n0, 1);
    chk("t2_no_err", last_err, 0);
    chk("t2_rx_drained", exp_q.size(), 0);

    max_fill = 0;
    for (int i = 0; i < 16; i++) load(8'(i));
    rx_ready_i = 1'b0;
    send_cmd(2'b01, 16'd16, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    chk("t3_hold_valid", rx_valid_o, 1);
    chk("t3_hold_data", rx_data_o, 8'h00);
    rx_ready_i = 1'b1;
    wait_done(3000, "t3");
    repeat (2) @(posedge clk);
    chk("t3_all_rx", exp_q.size(), 0);
    chk("t3_inflight_le4", max_fill <= 4, 1);
    chk("t3_no_ovf", bad, 0);
    chk("t3_ss_clr", ss_m, 8'h00);

    log_q.delete();
    load(8'h11); load(8'h22);
    send_cmd(2'b01, 16'd2, 1'b1);
    wait_done(600, "t4a");
    repeat (2) @(posedge clk);
    chk("t4_keep_no_clr", count_ent(12'hC00, 12'hFFF), 0);
    chk("t4_ss_kept", ss_m, 8'h01);
    load(8'h33); load(8'h44);
    send_cmd(2'b01, 16'd2, 1'b0);
    wait_done(600, "t4b");
    repeat (2) @(posedge clk);
    chk("t4_one_clr", count_ent(12'hC00, 12'hFFF), 1);
    chk("t4_ss_clr", ss_m, 8'h00);

    log_q.delete();
    send_cmd(2'b10, 16'd0, 1'b0);
    c = 0;
    while (!done_o && c < 30) begin
      @(posedge clk);
      c++;
      #1;
    end
    chk("t5_latency_le12", c <= 12, 1);
    repeat (3) @(posedge clk);
    chk("t5_no_spdr", count_ent(12'h200, 12'h700), 0);
    chk("t5_ss_set", count_ent(12'hC02, 12'hFFF), 1);
    chk("t5_ss_clr", ss_m, 8'h00);

`ifdef SPI_SEQ_TIMEOUT_EN
    stuck = 1'b1;
    txq.push_back(8'h5A);
    send_cmd(2'b01, 16'd1, 1'b0);
    wait_done(3000, "t6");
    repeat (2) @(posedge clk);
    chk("t6_err", last_err, 1);
    chk("t6_spe_off", spcr_m, 8'h13);
    chk("t6_ss_clr", ss_m, 8'h00);
    stuck = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
